alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALUctl code from the ALU control decoder, plus two 32-bit operands.
- Returns a registered result and a zero flag to the branch/writeback logic.
- Logic/arithmetic/compare ops complete in 1 cycle.
- Shifts use an iterative 1-bit-per-cycle shifter unless the fast-shift option is compiled in.
- valid/ready handshakes on both sides let the pipeline stall on multi-cycle shifts.

Parameters:
- XLEN, 32, operand/result width; shift amount is operand b[4:0].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  abort in-flight op and drop held result
- in_valid  in  1  operands/ALUctl valid
- in_ready  out  1  unit can accept this cycle
- ALUctl  in  4  operation code
- op_a  in  XLEN  operand A (shift source)
- op_b  in  XLEN  operand B (shift amount in [4:0])
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes result this cycle
- result  out  XLEN  registered result
- zero  out  1  registered (result == 0)

Behaviour:
- Ops and codes, defined in the shared constants file:
  - ADD=0 a+b, SUB=1 a-b (mod 2^32)
  - SLL=2, SLT=3 signed a<b →1/0, SLTU=4 unsigned
  - XOR=5, SRL=6 logical, SRA=7 arithmetic
  - OR=8, AND=9
  - Codes 10-15 are treated as ADD.
- States: IDLE, SHIFT.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Transfer occurs when in_valid && in_ready at a rising edge.
- Non-shift op, or shift with b[4:0]==0: result computed combinationally and written at the acceptance edge. out_valid=1 after that edge, so latency is 1.
- Shift with shamt≥1:
  - Acceptance edge loads the working reg with op_a, cnt with shamt, and the direction/arith flag; goes to SHIFT.
  - Each SHIFT edge shifts 1 bit (SRA replicates bit 31) and decrements cnt.
  - On the edge where cnt goes 1→0: write result, out_valid=1, go to IDLE.
  - Latency = shamt edges; max 31.
- in_ready=0 throughout SHIFT. In-flight operand inputs are ignored after acceptance.
- Output: result and zero stay stable while out_valid && !out_ready. Edge with out_valid && out_ready and no new write: out_valid→0, result keeps its value.
- Simultaneous consume and new accept at the same edge: the new result overwrites, and out_valid stays 1.
- flush (edge): state→IDLE, cnt→0, out_valid→0. Any same-edge acceptance is discarded. result and zero are unchanged.
- Priority: rst > flush > normal operation.
- Reset values: state IDLE, cnt 0, working reg 0, result 0, zero 0, out_valid 0.
- rst mid-SHIFT aborts the shift; nothing is emitted.
- in_ready is 1 in the first cycle after reset.

Optional Feature:
- Macro FAST_SHIFT_EN.
- Defined: SLL/SRL/SRA use a combinational barrel shifter, latency 1 for every op. The SHIFT state and cnt are not instantiated. in_ready = !out_valid || out_ready.
- Undefined: iterative shifter as above.
- Results are identical in both builds; only latency differs.

Decomposition:
- The shared constants file/package holds the ALUctl codes ADD..AND, shared with the ALU control decoder.
- State encoding stays local.
- One natural sub-module: alu_serial_shifter, which holds the working reg, cnt, start/done and direction/arith controls. It is not instantiated under FAST_SHIFT_EN.

Test Plan:
- ADD a=0x7FFFFFFF b=1, out_ready=1 → result 0x80000000 one edge after accept, zero=0. Then SUB a=5 b=5 → result 0, zero=1.
- SLT a=0xFFFFFFFF b=1 → 1. SLTU with the same operands → 0. Code 4'd12 a=2 b=3 → 5.
- SRA a=0x80000000 b=31 → in_ready low 31 cycles, result 0xFFFFFFFF after 31 edges. Same with FAST_SHIFT_EN → 1 edge.
- SLL a=1 b=0x20 (shamt 0) → result 1 in 1 cycle, no SHIFT entry.
- Backpressure: out_ready=0 after ADD 1+2 → result 3 held, in_ready=0. Raise out_ready with a new XOR 0xF0^0xFF at the same edge → result 0x0F, out_valid stays 1.
- SRL a=0x100 b=8, assert flush at cycle 3 → out_valid never rises, in_ready=1 the next cycle. Repeat with rst instead → all outputs at reset values.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: ALUctl operation codes shared with the ALU control decoder
package alu_exec_unit_pkg;
    localparam int SHAMT_W = 5;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;
    function automatic logic is_shift(input logic [3:0] op);
        return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
    endfunction
endpackage

// File: rtl/alu_exec_unit_shifter.sv
// alu_serial_shifter: 1-bit-per-cycle shifter used when FAST_SHIFT_EN is not defined
import alu_exec_unit_pkg::*;
module alu_serial_shifter #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               i_start,
    input  logic [XLEN-1:0]    i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic               i_left,
    input  logic               i_arith,
    output logic               o_done,
    output logic [XLEN-1:0]    o_next
);
    logic [XLEN-1:0]    r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_left;
    logic               r_arith;
    logic [XLEN-1:0]    w_next;
    assign w_next = r_left ? {r_work[XLEN-2:0], 1'b0} : {r_arith & r_work[XLEN-1], r_work[XLEN-1:1]};
    assign o_done = r_cnt == SHAMT_W'(1);
    assign o_next = w_next;
    // load operand and count on start, then shift one bit per cycle until the count drains
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work  <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_work  <= i_data;
            r_cnt   <= i_shamt;
            r_left  <= i_left;
            r_arith <= i_arith;
        end else if (r_cnt != '0) begin
            r_work <= w_next;
            r_cnt  <= r_cnt - SHAMT_W'(1);
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered result/zero; FAST_SHIFT_EN selects a barrel shifter
import alu_exec_unit_pkg::*;
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALUctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    logic [XLEN-1:0]    r_result;
    logic               r_zero;
    logic               r_out_valid;
    logic [XLEN-1:0]    w_alu;
    logic [XLEN-1:0]    w_wdata;
    logic               w_accept;
    logic               w_write;
    logic [SHAMT_W-1:0] w_shamt;
    assign w_shamt   = op_b[SHAMT_W-1:0];
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    // single-cycle ALU; unknown codes fall through to ADD
    always_comb begin
        w_alu = op_a + op_b;
        case (ALUctl)
            ALU_SUB:  w_alu = op_a - op_b;
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  w_alu = op_a ^ op_b;
            ALU_OR:   w_alu = op_a | op_b;
            ALU_AND:  w_alu = op_a & op_b;
`ifdef FAST_SHIFT_EN
            ALU_SLL:  w_alu = op_a << w_shamt;
            ALU_SRL:  w_alu = op_a >> w_shamt;
            ALU_SRA:  w_alu = $unsigned($signed(op_a) >>> w_shamt);
`else
            ALU_SLL, ALU_SRL, ALU_SRA: w_alu = op_a;
`endif
            default: ;
        endcase
    end
`ifdef FAST_SHIFT_EN
    assign in_ready = !r_out_valid || out_ready;
    assign w_write  = w_accept;
    assign w_wdata  = w_alu;
`else
    typedef enum logic {IDLE, SHIFT} state_e;
    state_e          r_state;
    logic            w_start;
    logic            w_sh_done;
    logic [XLEN-1:0] w_sh_next;
    assign in_ready = r_state == IDLE && (!r_out_valid || out_ready);
    assign w_start  = w_accept && is_shift(ALUctl) && w_shamt != '0;
    assign w_write  = (w_accept && !w_start) || (r_state == SHIFT && w_sh_done);
    assign w_wdata  = r_state == SHIFT ? w_sh_next : w_alu;
    alu_serial_shifter #(.XLEN(XLEN)) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .i_start (w_start),
        .i_data  (op_a),
        .i_shamt (w_shamt),
        .i_left  (ALUctl == ALU_SLL),
        .i_arith (ALUctl == ALU_SRA),
        .o_done  (w_sh_done),
        .o_next  (w_sh_next)
    );
`endif
    // output register and control FSM: write wins over consume, flush drops the held result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
`ifndef FAST_SHIFT_EN
            r_state     <= IDLE;
`endif
        end else if (flush) begin
            r_out_valid <= 1'b0;
`ifndef FAST_SHIFT_EN
            r_state     <= IDLE;
`endif
        end else begin
            if (w_write) begin
                r_result    <= w_wdata;
                r_zero      <= w_wdata == '0;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
`ifndef FAST_SHIFT_EN
            if (w_start)
                r_state <= SHIFT;
            else if (w_write)
                r_state <= IDLE;
`endif
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard-driven checks of alu_exec_unit in either shifter build
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  ALUctl = 4'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        zero;
    logic [31:0] result;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_r;
`ifdef FAST_SHIFT_EN
    localparam int SH_FAST = 1;
`else
    localparam int SH_FAST = 0;
`endif
    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUctl    (ALUctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );
    always #5 clk = ~clk;
    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        ALUctl = op; op_a = a; op_b = b; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        step();
        in_valid = 1'b0;
        op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0003;
    endtask
    task automatic wait_out(output int extra, output int low);
        extra = 0;
        low = 0;
        while (!out_valid && extra < 40) begin
            if (!in_ready) low++;
            step();
            extra++;
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (result !== 32'h0 || zero !== 1'b0) begin fails++; $display("FAIL reset_result got %h/%b exp 0/0", result, zero); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask
    task automatic test_arith();
        int ex, lo;
        out_ready = 1'b1;
        sb.push_back(32'h8000_0000);
        send(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        wait_out(ex, lo);
        exp_r = sb.pop_front();
        tests++; if (ex !== 0) begin fails++; $display("FAIL add_latency got %0d exp 0", ex); end
        tests++; if (result !== exp_r || zero !== (exp_r == 0)) begin fails++; $display("FAIL add got %h/%b exp %h/%b", result, zero, exp_r, exp_r == 0); end
        sb.push_back(32'h0);
        send(ALU_SUB, 32'd5, 32'd5);
        wait_out(ex, lo);
        exp_r = sb.pop_front();
        tests++; if (ex !== 0 || result !== exp_r || zero !== (exp_r == 0)) begin fails++; $display("FAIL sub got %h/%b lat %0d exp %h/%b", result, zero, ex, exp_r, exp_r == 0); end
    endtask
    task automatic test_compare();
        int ex, lo;
        logic [3:0] ops[3];
        logic [31:0] as[3];
        logic [31:0] bs[3];
        logic [31:0] es[3];
        ops = '{ALU_SLT, ALU_SLTU, 4'd12};
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        bs  = '{32'd1, 32'd1, 32'd3};
        es  = '{32'd1, 32'd0, 32'd5};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(es[i]);
            send(ops[i], as[i], bs[i]);
            wait_out(ex, lo);
            exp_r = sb.pop_front();
            tests++; if (ex !== 0 || result !== exp_r || zero !== (exp_r == 0)) begin fails++; $display("FAIL compare_%0d got %h/%b lat %0d exp %h/%b", i, result, zero, ex, exp_r, exp_r == 0); end
        end
    endtask
    task automatic test_shift();
        int ex, lo;
        logic [3:0] ops[4];
        logic [31:0] as[4];
        logic [31:0] bs[4];
        logic [31:0] es[4];
        int ls[4];
        ops = '{ALU_SRA, ALU_SLL, ALU_SRL, ALU_SLL};
        as  = '{32'h8000_0000, 32'h1, 32'h100, 32'h3};
        bs  = '{32'd31, 32'h20, 32'd8, 32'd4};
        es  = '{32'hFFFF_FFFF, 32'h1, 32'h1, 32'h30};
        ls  = '{31, 0, 8, 4};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(es[i]);
            send(ops[i], as[i], bs[i]);
            wait_out(ex, lo);
            exp_r = sb.pop_front();
            tests++; if (ex !== (SH_FAST ? 0 : ls[i])) begin fails++; $display("FAIL shift_%0d_latency got %0d exp %0d", i, ex, SH_FAST ? 0 : ls[i]); end
            tests++; if (lo !== (SH_FAST ? 0 : ls[i])) begin fails++; $display("FAIL shift_%0d_in_ready_low got %0d exp %0d", i, lo, SH_FAST ? 0 : ls[i]); end
            tests++; if (result !== exp_r || zero !== (exp_r == 0)) begin fails++; $display("FAIL shift_%0d got %h/%b exp %h", i, result, zero, exp_r); end
        end
    endtask
    task automatic test_backpressure();
        step();
        out_ready = 1'b0;
        sb.push_back(32'd3);
        send(ALU_ADD, 32'd1, 32'd2);
        exp_r = sb.pop_front();
        tests++; if (out_valid !== 1'b1 || result !== exp_r) begin fails++; $display("FAIL bp_first got %h/%b exp %h/1", result, out_valid, exp_r); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        step();
        step();
        tests++; if (out_valid !== 1'b1 || result !== exp_r || zero !== 1'b0) begin fails++; $display("FAIL bp_hold got %h/%b/%b exp %h/1/0", result, out_valid, zero, exp_r); end
        out_ready = 1'b1;
        sb.push_back(32'h0F);
        send(ALU_XOR, 32'hF0, 32'hFF);
        exp_r = sb.pop_front();
        tests++; if (out_valid !== 1'b1 || result !== exp_r || zero !== 1'b0) begin fails++; $display("FAIL bp_overwrite got %h/%b/%b exp %h/1/0", result, out_valid, zero, exp_r); end
    endtask
    task automatic test_flush();
        int rises;
        step();
`ifdef FAST_SHIFT_EN
        ALUctl = ALU_SRL; op_a = 32'h100; op_b = 32'd8; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
`else
        send(ALU_SRL, 32'h100, 32'd8);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
`endif
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_ready got in_ready %b out_valid %b exp 1/0", in_ready, out_valid); end
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) rises++;
        end
        tests++; if (rises !== 0) begin fails++; $display("FAIL flush_no_output got %0d valid cycles exp 0", rises); end
        tests++; if (result !== 32'h0F) begin fails++; $display("FAIL flush_result_kept got %h exp 0000000f", result); end
    endtask
    task automatic test_rst_shift();
        int rises;
`ifdef FAST_SHIFT_EN
        ALUctl = ALU_SRL; op_a = 32'h100; op_b = 32'd8; in_valid = 1'b1; rst = 1'b1;
        step();
        in_valid = 1'b0; rst = 1'b0;
`else
        send(ALU_SRL, 32'h100, 32'd8);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif
        tests++; if (result !== 32'h0 || zero !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rst_shift got %h/%b/%b/%b exp 0/0/0/1", result, zero, out_valid, in_ready); end
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) rises++;
        end
        tests++; if (rises !== 0) begin fails++; $display("FAIL rst_no_output got %0d valid cycles exp 0", rises); end
    endtask
    task automatic test_back_to_back();
        int ex, lo;
        out_ready = 1'b1;
        sb.push_back(32'hFF);
        send(ALU_OR, 32'hF0, 32'h0F);
        wait_out(ex, lo);
        exp_r = sb.pop_front();
        tests++; if (ex !== 0 || result !== exp_r) begin fails++; $display("FAIL b2b_or got %h lat %0d exp %h", result, ex, exp_r); end
        sb.push_back(32'h30);
        send(ALU_AND, 32'hF0, 32'h3C);
        wait_out(ex, lo);
        exp_r = sb.pop_front();
        tests++; if (ex !== 0 || result !== exp_r || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_and got %h/%b lat %0d exp %h/1", result, out_valid, ex, exp_r); end
    endtask
    initial begin
        test_reset();
        test_arith();
        test_compare();
        test_shift();
        test_backpressure();
        test_flush();
        test_rst_shift();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
